mem_bus_interface: RTL

//  Upstream stage of the 512x32 memory: holds MAR and MDR and sequences single-word memory reads/writes.

---
 rtl/mem_bus_interface.sv | 76 +++++++
 1 files changed

// File: rtl/mem_bus_interface.sv
// MAR/MDR holding stage in front of the 512x32 memory. Sequences single-word
// reads and writes and exposes a busy/done handshake to the control unit.
module mem_bus_interface #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] Mem_Dataout,
    output logic [DATA_W-1:0] Mem_Datain,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic              Mem_Write,
    output logic [DATA_W-1:0] MDR_q,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (MARin) r_mar <= BusMuxOut[ADDR_W-1:0];
                    if (MDRin) r_mdr <= BusMuxOut;
                end
                RD:      r_mdr <= Mem_Dataout;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            // Write wins over Read; a simultaneous Read is dropped.
            IDLE: begin
                if (Write)     w_next = WR;
                else if (Read) w_next = RD;
            end
            RD:      w_next = DONE;
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign Mem_Address = r_mar;
    assign Mem_Datain  = r_mdr;
    assign MDR_q       = r_mdr;
    // Gating with clr keeps a reset landing in WR from committing the write.
    assign Mem_Write   = (r_state == WR) && !clr;
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);

endmodule
